// File: rtl/jtkiwi_coldraw_if.sv
// Column renderer bus bundle: scanner request/busy handshake, graphics ROM
// fetch port and line-buffer write port. The scanner/system side is the
// master; the renderer is the slave.
interface jtkiwi_coldraw_if #(
  parameter int PALW = 5
);
  logic            draw;
  logic            busy;
  logic [15:0]     code;
  logic [15:0]     attr;
  logic [8:0]      xpos;
  logic [3:0]      ysub;
  logic [17:0]     rom_addr;
  logic            rom_cs;
  logic            rom_ok;
  logic [31:0]     rom_data;
  logic [8:0]      buf_addr;
  logic            buf_we;
  logic [PALW+3:0] buf_din;

  modport master (
    output draw, code, attr, xpos, ysub, rom_ok, rom_data,
    input  busy, rom_addr, rom_cs, buf_addr, buf_we, buf_din
  );

  modport slave (
    input  draw, code, attr, xpos, ysub, rom_ok, rom_data,
    output busy, rom_addr, rom_cs, buf_addr, buf_we, buf_din
  );
endinterface

// File: rtl/jtkiwi_coldraw.sv
// Tile-row renderer: takes one 16x16 4bpp tile row request, fetches the two
// 32-bit ROM words of that row and writes 16 pixels, one per clock, into the
// tilemap line buffer. All outputs are registered.
module jtkiwi_coldraw #(
  parameter int PALW       = 5,
  parameter bit ZERO_TRANS = 1'b1
) (
  input logic              clk,
  input logic              rst,
  jtkiwi_coldraw_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAW  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic            busy_r, busy_s;
  logic [12:0]     tile_r, tile_s;
  logic            vflip_r, vflip_s;
  logic            hflip_r, hflip_s;
  logic [PALW-1:0] pal_r, pal_s;
  logic [8:0]      xpos_r, xpos_s;
  logic [3:0]      ysub_r, ysub_s;
  logic            half_r, half_s;
  logic [2:0]      cnt_r, cnt_s;
  logic            wait_first_r, wait_first_s;
  logic [31:0]     shift_r, shift_s;
  logic [17:0]     rom_addr_r, rom_addr_s;
  logic            rom_cs_r, rom_cs_s;
  logic [8:0]      buf_addr_r, buf_addr_s;
  logic            buf_we_r, buf_we_s;
  logic [PALW+3:0] buf_din_r, buf_din_s;

  logic [3:0]      yeff_s;
  logic [3:0]      nib_s;
  logic            unused_s;

  // vflip selects the mirrored pixel row; hflip reads the shifter from the
  // low end so the leftmost pixel becomes the lowest nibble.
  assign yeff_s   = vflip_r ? ~ysub_r : ysub_r;
  assign nib_s    = hflip_r ? shift_r[3:0] : shift_r[31:28];
  assign unused_s = ^{bus.code[13], bus.attr};

  assign bus.busy     = busy_r;
  assign bus.rom_addr = rom_addr_r;
  assign bus.rom_cs   = rom_cs_r;
  assign bus.buf_addr = buf_addr_r;
  assign bus.buf_we   = buf_we_r;
  assign bus.buf_din  = buf_din_r;

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      tile_r       <= 13'd0;
      vflip_r      <= 1'b0;
      hflip_r      <= 1'b0;
      pal_r        <= '0;
      xpos_r       <= 9'd0;
      ysub_r       <= 4'd0;
      half_r       <= 1'b0;
      cnt_r        <= 3'd0;
      wait_first_r <= 1'b0;
      shift_r      <= 32'd0;
      rom_addr_r   <= 18'd0;
      rom_cs_r     <= 1'b0;
      buf_addr_r   <= 9'd0;
      buf_we_r     <= 1'b0;
      buf_din_r    <= '0;
    end else begin
      state_r      <= state_s;
      busy_r       <= busy_s;
      tile_r       <= tile_s;
      vflip_r      <= vflip_s;
      hflip_r      <= hflip_s;
      pal_r        <= pal_s;
      xpos_r       <= xpos_s;
      ysub_r       <= ysub_s;
      half_r       <= half_s;
      cnt_r        <= cnt_s;
      wait_first_r <= wait_first_s;
      shift_r      <= shift_s;
      rom_addr_r   <= rom_addr_s;
      rom_cs_r     <= rom_cs_s;
      buf_addr_r   <= buf_addr_s;
      buf_we_r     <= buf_we_s;
      buf_din_r    <= buf_din_s;
    end
  end

  // Next-state and next-output logic for the fetch/draw sequencer.
  always_comb begin
    state_s      = state_r;
    busy_s       = busy_r;
    tile_s       = tile_r;
    vflip_s      = vflip_r;
    hflip_s      = hflip_r;
    pal_s        = pal_r;
    xpos_s       = xpos_r;
    ysub_s       = ysub_r;
    half_s       = half_r;
    cnt_s        = cnt_r;
    wait_first_s = wait_first_r;
    shift_s      = shift_r;
    rom_addr_s   = rom_addr_r;
    rom_cs_s     = rom_cs_r;
    buf_addr_s   = buf_addr_r;
    buf_we_s     = 1'b0;
    buf_din_s    = buf_din_r;

    case (state_r)
      IDLE: begin
        // busy is still high for the slot carrying the last pixel write,
        // so it drops one cycle after entering IDLE.
        if (busy_r) begin
          busy_s = 1'b0;
        end else if (bus.draw) begin
          tile_s  = bus.code[12:0];
          vflip_s = bus.code[14];
          hflip_s = bus.code[15];
          pal_s   = bus.attr[15 -: PALW];
          xpos_s  = bus.xpos;
          ysub_s  = bus.ysub;
          half_s  = 1'b0;
          busy_s  = 1'b1;
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        rom_addr_s   = {tile_r, half_r ^ hflip_r, yeff_s};
        rom_cs_s     = 1'b1;
        wait_first_s = 1'b1;
        state_s      = WAIT;
      end
      WAIT: begin
        // First WAIT cycle skips rom_ok: it may still refer to the old address.
        if (wait_first_r) begin
          wait_first_s = 1'b0;
        end else if (bus.rom_ok) begin
          shift_s  = bus.rom_data;
          cnt_s    = 3'd0;
          rom_cs_s = 1'b0;
          state_s  = DRAW;
        end else begin
          state_s = WAIT;
        end
      end
      DRAW: begin
        rom_cs_s   = 1'b0;
        buf_addr_s = xpos_r + {5'd0, half_r, cnt_r};
        buf_din_s  = {pal_r, nib_s};
        buf_we_s   = ~(ZERO_TRANS && (nib_s == 4'd0));
        shift_s    = hflip_r ? (shift_r >> 4) : (shift_r << 4);
        cnt_s      = cnt_r + 3'd1;
        if (cnt_r == 3'd7) begin
          if (!half_r) begin
            half_s  = 1'b1;
            state_s = FETCH;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = DRAW;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule
